// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and
// frame-length arithmetic used by the TX block and the future RX block.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Clock cycles from start-bit entry until IDLE is re-entered.
    function automatic int frame_len(input int cpb, input int parity, input int stop_bits);
        return (10 + ((parity != PAR_NONE) ? 1 : 0) + (stop_bits - 1)) * cpb;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter; tick marks the last cycle of each bit
// period. Holding clear keeps the count at zero so a new bit starts aligned.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    output logic tick
);

    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/jtag_uart_tx.sv
// UART transmitter draining the host-to-JTAG byte FIFO: pops one byte per
// frame and serializes start, LSB-first data, optional parity and stop bits.
module jtag_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  fifo_q_i,
    input  logic        fifo_empty_i,
    output logic        fifo_rd_o,
    output logic        tx_o,
    output logic        busy_o,
    output logic [15:0] frames_o
);

    state_t     state;
    logic [7:0] shreg;
    logic       par_bit;
    logic [2:0] bit_idx;
    logic       stop_idx;
    logic       tick;
    logic       timer_clr;

    // Handshake: rdreq is asserted only from IDLE while the FIFO reports
    // data; the FIFO accepts it on that edge and presents the byte on
    // fifo_q_i during the following cycle (FETCH), where it is latched.
    assign fifo_rd_o = (state == ST_IDLE) & ~fifo_empty_i & ~rst_i;

    // IDLE and FETCH hold the timer at zero so START begins a full bit period.
    assign timer_clr = (state == ST_IDLE) || (state == ST_FETCH);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clear (timer_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            tx_o     <= 1'b1;
            busy_o   <= 1'b0;
            frames_o <= 16'd0;
            shreg    <= 8'd0;
            par_bit  <= 1'b0;
            bit_idx  <= 3'd0;
            stop_idx <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx_o <= 1'b1;
                    if (!fifo_empty_i) begin
                        state  <= ST_FETCH;
                        busy_o <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    shreg   <= fifo_q_i;
                    par_bit <= (PARITY == PAR_ODD) ? ~(^fifo_q_i) : ^fifo_q_i;
                    state   <= ST_START;
                    tx_o    <= 1'b0;
                end
                ST_START: begin
                    if (tick) begin
                        state   <= ST_DATA;
                        tx_o    <= shreg[0];
                        bit_idx <= 3'd0;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'd7) begin
                            stop_idx <= 1'b0;
                            if (PARITY != PAR_NONE) begin
                                state <= ST_PARITY;
                                tx_o  <= par_bit;
                            end else begin
                                state <= ST_STOP;
                                tx_o  <= 1'b1;
                            end
                        end else begin
                            shreg   <= shreg >> 1;
                            tx_o    <= shreg[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        state    <= ST_STOP;
                        tx_o     <= 1'b1;
                        stop_idx <= 1'b0;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (STOP_BITS == 1 || stop_idx) begin
                            state    <= ST_IDLE;
                            busy_o   <= 1'b0;
                            frames_o <= frames_o + 16'd1;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    tx_o   <= 1'b1;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_uart_tx.sv
// Bench for jtag_uart_tx: four parameter variants share one byte stream;
// each lane has a FIFO model, an expected-byte queue and a waveform monitor.
module tb_jtag_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'd0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic check(input int lane_id, input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL lane%0d %s at %0t: got %h expected %h", lane_id, name, $time, act, exp);
        end
    endtask

    // Line level of bit slot idx in a frame: start, 8 data bits, parity, stops.
    function automatic logic exp_level(input logic [7:0] b, input int par, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (par != 0 && idx == 9) return (par == 1) ? ^b : ~(^b);
        return 1'b1;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : lane
        localparam int C   = (g == 3) ? 2 : 4;
        localparam int P   = (g == 1) ? 1 : ((g == 2) ? 2 : 0);
        localparam int S   = (g == 1 || g == 2) ? 2 : 1;
        localparam int LEN = (10 + ((P != 0) ? 1 : 0) + (S - 1)) * C;

        logic        rd;
        logic        tx;
        logic        busy;
        logic [15:0] frames;
        logic [7:0]  q = 8'd0;
        logic        empty = 1'b1;
        logic [7:0]  fifo[$];

        logic [7:0]  exp_q[$];
        int          cyc = 0;
        bit          active = 1'b0;
        int          t0 = 0;
        logic [7:0]  cur = 8'd0;
        logic [15:0] exp_frames = 16'd0;
        bit          done_v = 1'b1;

        jtag_uart_tx #(
            .CLKS_PER_BIT(C),
            .PARITY      (P),
            .STOP_BITS   (S)
        ) dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .fifo_q_i    (q),
            .fifo_empty_i(empty),
            .fifo_rd_o   (rd),
            .tx_o        (tx),
            .busy_o      (busy),
            .frames_o    (frames)
        );

        always @(posedge clk) begin
            if (rd && fifo.size() > 0) q <= fifo.pop_front();
            if (wr_en) fifo.push_back(wr_data);
            empty <= (fifo.size() == 0);
        end

        always @(negedge clk) begin
            bit   in_frame;
            logic tx_e;
            logic rd_e;
            cyc++;
            if (active && cyc == t0 + LEN) begin
                active = 1'b0;
                exp_frames = exp_frames + 16'd1;
            end
            in_frame = active && (cyc >= t0 - 1);
            tx_e = (active && cyc >= t0) ? exp_level(cur, P, (cyc - t0) / C) : 1'b1;
            rd_e = !in_frame && !empty && !rst;
            check(g, "tx", {15'd0, tx}, {15'd0, tx_e});
            check(g, "busy", {15'd0, busy}, {15'd0, in_frame});
            check(g, "fifo_rd", {15'd0, rd}, {15'd0, rd_e});
            check(g, "frames", frames, exp_frames);
            if (wr_en) exp_q.push_back(wr_data);
            if (rst) begin
                active = 1'b0;
                exp_frames = 16'd0;
            end else if (rd) begin
                if (exp_q.size() == 0) begin
                    check(g, "pop_without_data", 16'd1, 16'd0);
                end else begin
                    cur = exp_q.pop_front();
                    active = 1'b1;
                    t0 = cyc + 2;
                end
            end
            done_v = !active && (exp_q.size() == 0);
        end
    end

    task automatic push_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        wr_en = 1'b1;
        wr_data = b;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input int n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            if (lane[0].done_v && lane[1].done_v && lane[2].done_v && lane[3].done_v) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_%s: lanes still busy after %0d cycles, required idle", name, bound);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_cycles(2);
        push_byte(8'h55);
        idle_cycles(1);
        rst = 1'b0;
        wait_done(400, "first_byte");

        push_byte(8'hA5);
        push_byte(8'h3C);
        wait_done(400, "two_bytes");

        push_byte(8'h07);
        wait_done(400, "parity_byte");

        push_byte(8'hFF);
        push_byte(8'h81);
        idle_cycles(17);
        rst = 1'b1;
        idle_cycles(1);
        rst = 1'b0;
        wait_done(400, "after_reset");

        idle_cycles(1000);
        push_byte(8'h5A);
        wait_done(400, "after_empty");

        for (int i = 0; i < 40; i++) begin
            push_byte(8'($urandom_range(0, 255)));
            idle_cycles($urandom_range(0, 3));
            if (i == 25) begin
                idle_cycles($urandom_range(5, 30));
                pulse_reset($urandom_range(1, 3));
            end
        end
        wait_done(6000, "random");

        idle_cycles(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
